// File: rtl/axi_rd_pkg.sv
// Shared constants, FSM state encoding and arsize helper for the read concentrator.
package axi_rd_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // Bytes-per-beat encoding for arsize.
  function automatic logic [2:0] size_enc(input int unsigned dw);
    case (dw)
      8:       size_enc = 3'd0;
      16:      size_enc = 3'd1;
      32:      size_enc = 3'd2;
      64:      size_enc = 3'd3;
      128:     size_enc = 3'd4;
      default: size_enc = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan channels starting at ptr; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] c;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = IDX_W'((int'(ptr_i) + k) % NUM_CH);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-channel AXI4 read concentrator: round-robin grant, one burst in flight,
// zero-latency beat routing with backpressure, and rid/rresp/rlast checks.
// Optional sticky per-channel error status: define AXI_RD_ERR_STICKY_EN.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_CH-1:0]            rsp_valid,
  input  logic [NUM_CH-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_last,
  output logic [1:0]                   rsp_resp,
  output logic                         busy,
  output logic                         err_pulse,
`ifdef AXI_RD_ERR_STICKY_EN
  input  logic                         err_clr,
  output logic [NUM_CH-1:0]            err_status,
`endif
  output logic [ID_WIDTH-1:0]          arid_m_inf,
  output logic [ADDR_WIDTH-1:0]        araddr_m_inf,
  output logic [LEN_WIDTH-1:0]         arlen_m_inf,
  output logic [2:0]                   arsize_m_inf,
  output logic [1:0]                   arburst_m_inf,
  output logic                         arvalid_m_inf,
  input  logic                         arready_m_inf,
  input  logic [ID_WIDTH-1:0]          rid_m_inf,
  input  logic [DATA_WIDTH-1:0]        rdata_m_inf,
  input  logic [1:0]                   rresp_m_inf,
  input  logic                         rlast_m_inf,
  input  logic                         rvalid_m_inf,
  output logic                         rready_m_inf
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = LEN_WIDTH + 1;   // extra bit so overrun beats don't alias len

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [NUM_CH-1:0]     gnt;
  logic [IDX_W-1:0]      gidx;
  logic                  beat;

  logic [ADDR_WIDTH-1:0] addr_a [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_a  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // Channel-facing and AXI-facing combinational outputs, gated by state.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_data      = '0;
    rsp_last      = 1'b0;
    rsp_resp      = '0;
    rready_m_inf  = 1'b0;
    arvalid_m_inf = 1'b0;
    arid_m_inf    = '0;
    araddr_m_inf  = '0;
    arlen_m_inf   = '0;
    arsize_m_inf  = '0;
    arburst_m_inf = '0;
    case (state_q)
      S_IDLE: req_ready = gnt;
      S_ADDR: begin
        arvalid_m_inf = 1'b1;
        arid_m_inf    = ID_WIDTH'(owner_q);
        araddr_m_inf  = addr_q;
        arlen_m_inf   = len_q;
        arsize_m_inf  = size_enc(DATA_WIDTH);
        arburst_m_inf = BURST_INCR;
      end
      S_DATA: begin
        rready_m_inf       = rsp_ready[owner_q];
        rsp_valid[owner_q] = rvalid_m_inf;
        rsp_data           = rdata_m_inf;
        rsp_last           = rlast_m_inf;
        rsp_resp           = rresp_m_inf;
      end
      default: ;
    endcase
  end

  assign beat      = (state_q == S_DATA) && rvalid_m_inf && rready_m_inf;
  assign busy      = (state_q != S_IDLE);
  assign err_pulse = err_q;

  // Next-state: grant capture, address handshake, beat counting, error detect.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          owner_d  = gidx;
          addr_d   = addr_a[gidx];
          len_d    = len_a[gidx];
          rr_ptr_d = (gidx == IDX_W'(NUM_CH-1)) ? '0 : gidx + 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready_m_inf) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          err_d = (rid_m_inf != ID_WIDTH'(owner_q)) ||
                  (rresp_m_inf != RESP_OKAY) ||
                  ( rlast_m_inf && (cnt_q != CNT_W'(len_q))) ||
                  (!rlast_m_inf && (cnt_q == CNT_W'(len_q)));
          if (rlast_m_inf) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

`ifdef AXI_RD_ERR_STICKY_EN
  logic [NUM_CH-1:0] err_status_q, err_status_d;

  // Sticky per-owner error flags; a new error wins over a same-cycle clear.
  always_comb begin
    err_status_d = err_status_q;
    if (err_clr) err_status_d = '0;
    if (err_d)   err_status_d[owner_q] = 1'b1;
  end

  // Sticky status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_status_q <= '0;
    else        err_status_q <= err_status_d;
  end

  assign err_status = err_status_q;
`endif

endmodule
